mult_seq_param: RTL and testbench
=================================

MULT_SEQ_PARAM -- requirements
Module: mult_seq_param

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; must be a multiple of DIGIT and at least DIGIT.
REQ-002 SHALL have parameter DIGIT, default 4, digit width in bits of the per-cycle partial multiplier.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-007 SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-008 SHALL have ports a and b, input, WIDTH bits each: operands; sampled with start.
REQ-009 SHALL have port d_out, output, 2*WIDTH bits: registered product.
REQ-010 SHALL have port busy, output, 1 bit: high in MULT and FIX.
REQ-011 SHALL have port done_flag, output, 1 bit: one-cycle pulse when d_out is updated.
REQ-012 SHALL have port state, output, 3 bits: current FSM state code, for the seven-segment display.

Function
REQ-013 SHALL define K = WIDTH/DIGIT; FSM states SHALL be IDLE=0, MULT=1, FIX=2, DONE=3.
REQ-014 On an edge in IDLE with start=1, SHALL do all of the following:
- latch |a| and |b| (magnitude only when signed_mode=1, else raw);
- latch sign = signed_mode & (a[MSB] ^ b[MSB]);
- clear the 2*WIDTH accumulator;
- clear digit indices i, j;
- go to MULT.
REQ-015 A magnitude of -2^(WIDTH-1) SHALL be represented as unsigned 2^(WIDTH-1) in WIDTH bits, without overflow.
REQ-016 Each MULT edge SHALL add zero-extended (A digit i × B digit j) << ((i+j)*DIGIT) to the accumulator.
- j SHALL increment every edge and wrap to 0 after K-1.
- i SHALL increment on each j wrap.
REQ-017 After exactly K*K MULT edges, the FSM SHALL go to FIX.
REQ-018 The FIX edge SHALL load d_out with the accumulator, or its two's-complement negation if sign=1, and go to DONE.
REQ-019 done_flag SHALL be high for exactly the one cycle spent in DONE; DONE SHALL return to IDLE unconditionally.
REQ-020 Latency: done_flag SHALL be high in the cycle after the (K*K+1)-th edge following the start-sampling edge (17 for WIDTH=16, DIGIT=4).
REQ-021 d_out SHALL hold its previous value through MULT and until the next FIX edge.
REQ-022 start SHALL be ignored in MULT, FIX and DONE.
- start held high through DONE SHALL begin a new operation on the first IDLE edge.
REQ-023 Changes on a, b or signed_mode after the start-sampling edge SHALL NOT affect the running result.
REQ-024 Accumulator arithmetic SHALL be modulo 2^(2*WIDTH); the true product always fits, so no overflow flag is provided.

Reset
REQ-025 With rst=1 at an edge, the block SHALL set state=IDLE, d_out=0, busy=0, done_flag=0, accumulator=0, i=j=0 and sign=0.
REQ-026 rst SHALL override start, including mid-operation.
- A partial result SHALL never reach d_out.
- done_flag SHALL NOT pulse for an aborted operation.

Structure
REQ-027 State codes and the K derivation SHALL live in shared package mult_pkg.
REQ-028 The DIGIT×DIGIT unsigned combinational multiplier SHALL be a sub-module named mult_digit, instanced once.
REQ-029 Digit select, shift and add SHALL be inline datapath; the FSM and indices SHALL be a single registered process.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-030 Unsigned case SHALL be covered: a=0x00FF, b=0x00FF, signed_mode=0, start -> d_out=0x0000FE01 and done_flag one cycle high exactly 17 edges after start; busy high for 17 cycles.
REQ-031 Signed cases SHALL be covered:
- a=0xFFFD (-3), b=0x0005, signed_mode=1 -> d_out=0xFFFFFFF1;
- a=b=0x8000, signed_mode=1 -> d_out=0x40000000;
- a=b=0x8000, signed_mode=0 -> d_out=0x40000000.
REQ-032 Operand hold and busy start SHALL be covered: after start with a=0x1234, b=0x0010, change a/b and pulse start during MULT -> d_out=0x00012340 and only one done_flag pulse.
REQ-033 Mid-operation reset SHALL be covered: rst at MULT cycle 8 -> next cycle state=0, d_out=0, done_flag never pulses; a following start computes correctly.
REQ-034 Second parameter set SHALL be covered: WIDTH=8, DIGIT=4, a=b=0xFF, signed_mode=0 -> d_out=0xFE01, done_flag 5 edges after start.
REQ-035 The bench SHALL compare d_out against a reference model for 1000 random operand pairs in both modes.

Source files
------------

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module : mult_pkg
// Brief  : Shared definitions for the sequential digit-serial multiplier:
//          FSM state codes and the digit-count derivation.
// Ports  : (package, no ports)
// Rev    : 1.0  initial release
// ============================================================================
package mult_pkg;

   // State codes are visible on the external state port, so the values are
   // fixed rather than left to the tools.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      MULT = 3'd1,
      FIX  = 3'd2,
      DONE = 3'd3
   } state_t;

   // Number of DIGIT-wide digits in a WIDTH-wide operand.
   function automatic int calc_k(input int width, input int digit);
      return width / digit;
   endfunction

   // Index register width; at least one bit so that K = 1 still elaborates.
   function automatic int idx_bits(input int k);
      return (k > 1) ? $clog2(k) : 1;
   endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_digit.sv
`default_nettype none
// ============================================================================
// Module : mult_digit
// Brief  : Unsigned DIGIT x DIGIT combinational multiplier. This is the only
//          multiplier in the design; the top reuses it every MULT cycle.
// Ports  : x, y  - DIGIT-bit unsigned digits
//          p     - 2*DIGIT-bit unsigned product
// Rev    : 1.0  initial release
// ============================================================================
module mult_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0]   x,
   input  logic [DIGIT-1:0]   y,
   output logic [2*DIGIT-1:0] p
);

   // Operands are zero-extended to the product width so that the multiply is
   // evaluated at full width with no truncation.
   assign p = {{DIGIT{1'b0}}, x} * {{DIGIT{1'b0}}, y};

endmodule : mult_digit
`default_nettype wire

// File: rtl/mult_seq_param.sv
`default_nettype none
// ============================================================================
// Module : mult_seq_param
// Brief  : Sequential signed/unsigned multiplier. Operand magnitudes are
//          multiplied one digit pair per cycle (K*K cycles, K = WIDTH/DIGIT).
//          The sign is applied in a single FIX cycle before the product is
//          published on d_out.
// Ports  : clk          - rising-edge clock
//          rst          - synchronous active-high reset
//          start        - multiply request, honoured only in IDLE
//          signed_mode  - 1: two's-complement operands, 0: unsigned
//          a, b         - WIDTH-bit operands, sampled with start
//          d_out        - 2*WIDTH-bit registered product
//          busy         - high in MULT and FIX
//          done_flag    - one-cycle pulse while in DONE (d_out just updated)
//          state        - current FSM state code
// Rev    : 1.0  initial release
// ============================================================================
module mult_seq_param
   import mult_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] d_out,
   output logic               busy,
   output logic               done_flag,
   output logic [2:0]         state
);

   localparam int K  = calc_k(WIDTH, DIGIT);
   localparam int IW = idx_bits(K);
   localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

   // ------------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------------
   state_t             cur_state;
   state_t             next_state;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               sign;
   logic [2*WIDTH-1:0] acc;
   logic [IW-1:0]      idx_i;
   logic [IW-1:0]      idx_j;

   // ------------------------------------------------------------------------
   // Operand magnitudes. The negation is done in WIDTH bits, so the most
   // negative value maps onto its own bit pattern, which read as unsigned is
   // exactly 2^(WIDTH-1) -- no extra bit needed.
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;

   assign a_abs = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
   assign b_abs = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

   // ------------------------------------------------------------------------
   // Digit select, partial product, alignment
   // ------------------------------------------------------------------------
   logic [WIDTH-1:0]   a_shr;
   logic [WIDTH-1:0]   b_shr;
   logic [DIGIT-1:0]   a_dig;
   logic [DIGIT-1:0]   b_dig;
   logic [2*DIGIT-1:0] pp;
   logic [2*WIDTH-1:0] pp_ext;
   logic [31:0]        pp_shift;
   logic [2*WIDTH-1:0] pp_aligned;

   assign a_shr = a_mag >> (int'(idx_i) * DIGIT);
   assign b_shr = b_mag >> (int'(idx_j) * DIGIT);
   assign a_dig = a_shr[DIGIT-1:0];
   assign b_dig = b_shr[DIGIT-1:0];

   mult_digit #(
      .DIGIT (DIGIT)
   ) u_mult_digit (
      .x (a_dig),
      .y (b_dig),
      .p (pp)
   );

   assign pp_ext     = (2*WIDTH)'(pp);
   assign pp_shift   = 32'((int'(idx_i) + int'(idx_j)) * DIGIT);
   assign pp_aligned = pp_ext << pp_shift;

   // The last digit pair is the K*K-th MULT cycle.
   logic last_step;
   assign last_step = (idx_i == LAST_IDX) && (idx_j == LAST_IDX);

   // ------------------------------------------------------------------------
   // Next-state logic and state-decoded outputs
   // ------------------------------------------------------------------------
   always_comb begin
      next_state = cur_state;
      busy       = 1'b0;
      done_flag  = 1'b0;
      state      = cur_state;
      case (cur_state)
         IDLE: begin
            if (start) begin
               next_state = MULT;
            end
         end
         MULT: begin
            busy = 1'b1;
            if (last_step) begin
               next_state = FIX;
            end
         end
         FIX: begin
            busy       = 1'b1;
            next_state = DONE;
         end
         DONE: begin
            done_flag  = 1'b1;
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State register, digit indices and datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state <= IDLE;
         d_out     <= '0;
         acc       <= '0;
         a_mag     <= '0;
         b_mag     <= '0;
         sign      <= 1'b0;
         idx_i     <= '0;
         idx_j     <= '0;
      end else begin
         cur_state <= next_state;
         case (cur_state)
            IDLE: begin
               if (start) begin
                  a_mag <= a_abs;
                  b_mag <= b_abs;
                  sign  <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc   <= '0;
                  idx_i <= '0;
                  idx_j <= '0;
               end
            end
            MULT: begin
               acc <= acc + pp_aligned;
               if (idx_j == LAST_IDX) begin
                  idx_j <= '0;
                  idx_i <= idx_i + IW'(1);
               end else begin
                  idx_j <= idx_j + IW'(1);
               end
            end
            FIX: begin
               d_out <= sign ? (~acc + (2*WIDTH)'(1)) : acc;
            end
            default: begin
            end
         endcase
      end
   end

endmodule : mult_seq_param
`default_nettype wire

// File: tb/tb_mult_seq_param.sv
`default_nettype none
// ============================================================================
// Module : tb_mult_seq_param
// Brief  : Self-checking bench for mult_seq_param, instancing a 16/4 and an
//          8/4 configuration. Expected products come from plain integer
//          multiplication of the (sign- or zero-extended) operands.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mult_seq_param;

   logic        clk = 1'b0;
   logic        rst;

   logic        start, sm;
   logic [15:0] a, b;
   logic [31:0] d_out;
   logic        busy, done_flag;
   logic [2:0]  state;

   logic        start8, sm8;
   logic [7:0]  a8, b8;
   logic [15:0] d_out8;
   logic        busy8, done8;
   logic [2:0]  state8;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   mult_seq_param #(.WIDTH(16), .DIGIT(4)) dut16 (
      .clk(clk), .rst(rst), .start(start), .signed_mode(sm), .a(a), .b(b),
      .d_out(d_out), .busy(busy), .done_flag(done_flag), .state(state)
   );

   mult_seq_param #(.WIDTH(8), .DIGIT(4)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
      .d_out(d_out8), .busy(busy8), .done_flag(done8), .state(state8)
   );

   // ------------------------------------------------------------------------
   // Reference model: ordinary integer product, truncated to 2*WIDTH.
   // ------------------------------------------------------------------------
   function automatic logic [31:0] model16(input logic [15:0] x, input logic [15:0] y,
                                           input logic s);
      longint px, py;
      if (s) begin
         px = longint'($signed(x));
         py = longint'($signed(y));
      end else begin
         px = longint'(x);
         py = longint'(y);
      end
      return 32'(px * py);
   endfunction

   function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y,
                                          input logic s);
      longint px, py;
      if (s) begin
         px = longint'($signed(x));
         py = longint'($signed(y));
      end else begin
         px = longint'(x);
         py = longint'(y);
      end
      return 16'(px * py);
   endfunction

   // ------------------------------------------------------------------------
   // Drivers: launch one operation and wait (bounded) for done_flag.
   // lat = edges after the start-sampling edge, -1 on timeout.
   // ------------------------------------------------------------------------
   task automatic run_op16(input logic [15:0] xa, input logic [15:0] xb, input logic xs,
                           output logic [31:0] res, output int lat, output int busy_cyc);
      @(posedge clk); #1;
      a = xa; b = xb; sm = xs; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1;
      busy_cyc = 0;
      if (busy) busy_cyc++;
      for (int e = 1; e <= 60; e++) begin
         @(posedge clk); #1;
         if (done_flag) begin
            lat = e;
            break;
         end
         if (busy) busy_cyc++;
      end
      res = d_out;
   endtask

   task automatic run_op8(input logic [7:0] xa, input logic [7:0] xb, input logic xs,
                          output logic [15:0] res, output int lat);
      @(posedge clk); #1;
      a8 = xa; b8 = xb; sm8 = xs; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat = -1;
      for (int e = 1; e <= 30; e++) begin
         @(posedge clk); #1;
         if (done8) begin
            lat = e;
            break;
         end
      end
      res = d_out8;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", state); else passes++;
      checks++; if (d_out !== 32'h0) $display("FAIL reset_dout got=%h exp=0", d_out); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passes++;
      checks++; if (done_flag !== 1'b0) $display("FAIL reset_done got=%b exp=0", done_flag); else passes++;
      checks++; if (d_out8 !== 16'h0 || state8 !== 3'd0)
         $display("FAIL reset_dut8 got d=%h st=%0d exp d=0 st=0", d_out8, state8); else passes++;
      rst = 1'b0;
   endtask

   task automatic test_unsigned;
      logic [31:0] res; int lat, bc;
      run_op16(16'h00FF, 16'h00FF, 1'b0, res, lat, bc);
      checks++; if (res !== 32'h0000FE01) $display("FAIL unsigned_ff got=%h exp=0000fe01", res); else passes++;
      checks++; if (lat !== 17) $display("FAIL unsigned_latency got=%0d exp=17", lat); else passes++;
      checks++; if (bc !== 17) $display("FAIL unsigned_busy_cycles got=%0d exp=17", bc); else passes++;
      @(posedge clk); #1;
      checks++; if (done_flag !== 1'b0 || state !== 3'd0)
         $display("FAIL done_one_cycle got done=%b st=%0d exp done=0 st=0", done_flag, state); else passes++;
   endtask

   task automatic test_signed;
      logic [31:0] res; int lat, bc;
      run_op16(16'hFFFD, 16'h0005, 1'b1, res, lat, bc);
      checks++; if (res !== 32'hFFFFFFF1 || lat !== 17)
         $display("FAIL signed_m3x5 got=%h lat=%0d exp=fffffff1 lat=17", res, lat); else passes++;
      run_op16(16'h8000, 16'h8000, 1'b1, res, lat, bc);
      checks++; if (res !== 32'h40000000)
         $display("FAIL signed_min_sq got=%h exp=40000000", res); else passes++;
      run_op16(16'h8000, 16'h8000, 1'b0, res, lat, bc);
      checks++; if (res !== 32'h40000000)
         $display("FAIL unsigned_8000_sq got=%h exp=40000000", res); else passes++;
   endtask

   // Operands and start change during MULT; d_out must hold the previous
   // product (0x40000000) until the new one lands.
   task automatic test_operand_hold;
      int pulses = 0;
      logic [31:0] res = '0;
      @(posedge clk); #1;
      a = 16'h1234; b = 16'h0010; sm = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk); #1;
         if (e == 2) begin
            a = 16'hFFFF; b = 16'hFFFF; sm = 1'b1; start = 1'b1;
         end
         if (e == 3) start = 1'b0;
         if (e == 5) begin
            checks++; if (d_out !== 32'h40000000 || busy !== 1'b1)
               $display("FAIL hold_dout_mid got=%h busy=%b exp=40000000 busy=1", d_out, busy);
            else passes++;
         end
         if (done_flag) begin
            pulses++;
            res = d_out;
         end
      end
      checks++; if (res !== 32'h00012340) $display("FAIL hold_result got=%h exp=00012340", res); else passes++;
      checks++; if (pulses !== 1) $display("FAIL hold_done_pulses got=%0d exp=1", pulses); else passes++;
   endtask

   task automatic test_mid_reset;
      int pulses = 0;
      logic [31:0] res; int lat, bc;
      @(posedge clk); #1;
      a = 16'h00AB; b = 16'h0CD0; sm = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (7) @(posedge clk);
      #1; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++; if (state !== 3'd0 || d_out !== 32'h0 || busy !== 1'b0)
         $display("FAIL midreset_state got st=%0d d=%h busy=%b exp st=0 d=0 busy=0", state, d_out, busy);
      else passes++;
      for (int e = 0; e < 30; e++) begin
         @(posedge clk); #1;
         if (done_flag) pulses++;
      end
      checks++; if (pulses !== 0 || d_out !== 32'h0)
         $display("FAIL midreset_no_done got pulses=%0d d=%h exp pulses=0 d=0", pulses, d_out); else passes++;
      run_op16(16'h0ABC, 16'h1DEF, 1'b0, res, lat, bc);
      checks++; if (res !== model16(16'h0ABC, 16'h1DEF, 1'b0) || lat !== 17)
         $display("FAIL midreset_recover got=%h lat=%0d exp=%h lat=17", res, lat,
                  model16(16'h0ABC, 16'h1DEF, 1'b0));
      else passes++;
   endtask

   // start held high through DONE launches the next operation on the first
   // IDLE edge: second done arrives 17 + 2 + 17 edges after the first start.
   task automatic test_back_to_back;
      int first_lat = -1, second_lat = -1;
      logic [31:0] r1 = '0, r2 = '0;
      @(posedge clk); #1;
      a = 16'h0102; b = 16'h0304; sm = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      for (int e = 1; e <= 60; e++) begin
         @(posedge clk); #1;
         if (done_flag) begin
            if (first_lat < 0) begin
               first_lat = e; r1 = d_out;
               a = 16'hFFF0; b = 16'h0011; sm = 1'b1;
            end else begin
               second_lat = e; r2 = d_out;
               break;
            end
         end
      end
      start = 1'b0;
      checks++; if (r1 !== model16(16'h0102, 16'h0304, 1'b0) || first_lat !== 17)
         $display("FAIL b2b_first got=%h lat=%0d exp=%h lat=17", r1, first_lat,
                  model16(16'h0102, 16'h0304, 1'b0));
      else passes++;
      checks++; if (r2 !== model16(16'hFFF0, 16'h0011, 1'b1) || second_lat !== 36)
         $display("FAIL b2b_second got=%h lat=%0d exp=%h lat=36", r2, second_lat,
                  model16(16'hFFF0, 16'h0011, 1'b1));
      else passes++;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_width8;
      logic [15:0] res, exp; int lat;
      logic [7:0] xa, xb; logic xs;
      run_op8(8'hFF, 8'hFF, 1'b0, res, lat);
      checks++; if (res !== 16'hFE01 || lat !== 5)
         $display("FAIL w8_ff got=%h lat=%0d exp=fe01 lat=5", res, lat); else passes++;
      run_op8(8'h80, 8'h7F, 1'b1, res, lat);
      checks++; if (res !== 16'hC080) $display("FAIL w8_signed got=%h exp=c080", res); else passes++;
      for (int n = 0; n < 100; n++) begin
         xa = 8'($urandom); xb = 8'($urandom); xs = 1'(n & 1);
         exp = model8(xa, xb, xs);
         run_op8(xa, xb, xs, res, lat);
         checks++; if (res !== exp || lat !== 5)
            $display("FAIL w8_random a=%h b=%h s=%b got=%h lat=%0d exp=%h lat=5", xa, xb, xs, res, lat, exp);
         else passes++;
      end
   endtask

   task automatic test_random;
      logic [31:0] res, exp; int lat, bc;
      logic [15:0] xa, xb; logic xs;
      for (int n = 0; n < 1000; n++) begin
         xa = 16'($urandom); xb = 16'($urandom); xs = 1'(n & 1);
         case (n % 50)
            0: xa = 16'h8000;
            1: xb = 16'hFFFF;
            2: xa = 16'h0000;
            3: begin xa = 16'h7FFF; xb = 16'h8000; end
            default: ;
         endcase
         exp = model16(xa, xb, xs);
         run_op16(xa, xb, xs, res, lat, bc);
         checks++; if (res !== exp || lat !== 17)
            $display("FAIL random a=%h b=%h s=%b got=%h lat=%0d exp=%h lat=17", xa, xb, xs, res, lat, exp);
         else passes++;
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0; sm = 1'b0; a = '0; b = '0;
      start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
      test_reset;
      test_unsigned;
      test_signed;
      test_operand_hold;
      test_mid_reset;
      test_back_to_back;
      test_width8;
      test_random;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule : tb_mult_seq_param
`default_nettype wire
